// File: rtl/gram_pkg.sv
// Shared definitions for the gram PE row: drain FSM encoding,
// derived widths and the pe_P lane helper used by feeder, PEs and drain.
package gram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    // Window counter width: must hold 0..DIMENSION.
    function automatic int cnt_w(input int dimension);
        return $clog2(dimension + 1);
    endfunction

    // PE index width, at least 1 bit even for a single-PE row.
    function automatic int idx_w(input int num_pe);
        return (num_pe > 1) ? $clog2(num_pe) : 1;
    endfunction

    // LSB of PE k's lane inside a packed NUM_PE*WIDTH bus.
    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/gram_snap_buf.sv
// Two-slot FIFO of row snapshots (NUM_PE words each), read a word at a time.
// Ports: clk, rst (async, active-low), wr_en/wr_data push a snapshot,
//   rd_idx selects a word of the head slot on rd_word, pop frees the head,
//   full/empty report occupancy. Pop and write in one cycle is legal when full.
module gram_snap_buf
    import gram_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_PE = 4,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [NUM_PE*WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [WIDTH-1:0]        rd_word,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty
);

    logic [NUM_PE*WIDTH-1:0] slot [2];
    logic [NUM_PE*WIDTH-1:0] head;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            // When full, wr_ptr == rd_ptr: a write alongside pop
            // reuses the slot being drained this cycle.
            if (wr_en) begin
                slot[wr_ptr] <= wr_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, pop};
        end
    end

    assign head    = slot[rd_ptr];
    assign rd_word = head[lane_lsb(int'(rd_idx), WIDTH) +: WIDTH];
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);

endmodule

// File: rtl/gram_result_drain.sv
// Collects complete DIMENSION-term dot products from a PE row and streams
// them out one word per beat.
// Ports: clk, rst (async, active-low); pe_en_o/pe_P from the PE row;
//   out_data/out_idx/out_last/out_valid/out_ready word stream;
//   overflow sticky drop flag, clr_ovf synchronous clear.
module gram_result_drain
    import gram_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIMENSION = 256,
    parameter int NUM_PE    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pe_en_o,
    input  logic [NUM_PE*WIDTH-1:0]   pe_P,
    output logic [WIDTH-1:0]          out_data,
    output logic [idx_w(NUM_PE)-1:0]  out_idx,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    input  logic                      clr_ovf
);

    localparam int CNT_W = cnt_w(DIMENSION);
    localparam int IDX_W = idx_w(NUM_PE);

    drain_state_t     state;
    drain_state_t     state_n;
    logic [CNT_W-1:0] cnt;
    logic             snap;
    logic             beat;
    logic             is_last;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rd_word;

    assign snap    = pe_en_o && (cnt == CNT_W'(DIMENSION - 1));
    assign beat    = out_valid && out_ready;
    assign is_last = (out_idx == IDX_W'(NUM_PE - 1));
    assign pop     = beat && is_last;
    // A last-word pop this cycle frees the head in time for the write.
    assign wr_en   = snap && (!full || pop);
    assign drop    = snap && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!pe_en_o || snap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_idx <= '0;
        end else if (beat) begin
            out_idx <= is_last ? '0 : out_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (wr_en || !empty) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                // Leave only when the last word drains the only slot
                // and nothing new arrives on the same edge.
                if (pop && !full && !wr_en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Head slot is frozen until its last word pops, so the
    // presented word is stable for as long as it is stalled.
    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? rd_word : '0;
    assign out_last  = out_valid && is_last;

    gram_snap_buf #(
        .WIDTH  (WIDTH),
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (pe_P),
        .rd_idx  (out_idx),
        .rd_word (rd_word),
        .pop     (pop),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_gram_result_drain.sv
// Scoreboard bench for gram_result_drain (WIDTH=8, DIMENSION=4, NUM_PE=2).
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_gram_result_drain;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       idx;
        logic       last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           pe_en_o;
    logic [N*W-1:0] pe_P;
    logic [W-1:0]   out_data;
    logic [0:0]     out_idx;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic           overflow;
    logic           clr_ovf;

    beat_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;

    logic [7:0] p0 [4] = '{8'd1, 8'd3, 8'd6, 8'd10};
    logic [7:0] p1 [4] = '{8'd2, 8'd4, 8'd6, 8'd8};

    gram_result_drain #(
        .WIDTH     (W),
        .DIMENSION (D),
        .NUM_PE    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pe_en_o   (pe_en_o),
        .pe_P      (pe_P),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on handshake, stability while stalled.
    logic       prev_stall = 1'b0;
    logic [7:0] pd;
    logic       pi;
    logic       pl;

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, pd);
                check("stall_idx", out_idx, pi);
                check("stall_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h idx %0d, none expected",
                             out_data, out_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.d);
                    check("beat_idx", out_idx, e.idx);
                    check("beat_last", out_last, e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx[0];
            pl = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [7:0] d0, input logic [7:0] d1);
        exp_q.push_back('{d0, 1'b0, 1'b0});
        exp_q.push_back('{d1, 1'b1, 1'b1});
    endtask

    // One full window; final beat carries f0/f1. out_ready rises at
    // beat ready_at (negative: leave it alone).
    task automatic window(input logic [7:0] f0, input logic [7:0] f1,
                          input int ready_at);
        for (int i = 0; i < D; i++) begin
            pe_en_o = 1'b1;
            if (i == D - 1) pe_P = {f1, f0};
            else pe_P = {8'hE0 + 8'(i), 8'hF0 + 8'(i)};
            if (i == ready_at) out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] r0;
        logic [7:0] r1;
        rst       = 1'b0;
        pe_en_o   = 1'b0;
        pe_P      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b1;
        tick();

        // 1: single window
        out_ready = 1'b1;
        push2(8'd10, 8'd8);
        for (int i = 0; i < D; i++) begin
            pe_en_o = 1'b1;
            pe_P    = {p1[i], p0[i]};
            tick();
        end
        pe_en_o = 1'b0;
        check("t1_latency", out_valid, 1);
        drain(10);
        check("t1_idle", out_valid, 0);

        // 2: broken window then full window
        for (int i = 0; i < 3; i++) begin
            pe_en_o = 1'b1;
            pe_P    = {8'h22 + 8'(i), 8'h11 + 8'(i)};
            tick();
        end
        pe_en_o = 1'b0;
        tick();
        check("t2_no_snap", out_valid, 0);
        push2(8'h55, 8'hAA);
        window(8'h55, 8'hAA, -1);
        pe_en_o = 1'b0;
        drain(10);
        check("t2_idle", out_valid, 0);

        // 3: backpressure, third snapshot dropped
        out_ready = 1'b0;
        push2(8'h01, 8'h02);
        window(8'h01, 8'h02, -1);
        push2(8'h03, 8'h04);
        window(8'h03, 8'h04, -1);
        check("t3_ovf_before", overflow, 0);
        window(8'h05, 8'h06, -1);
        pe_en_o = 1'b0;
        check("t3_ovf_set", overflow, 1);
        repeat (8) tick();
        check("t3_hold_data", out_data, 8'h01);
        out_ready = 1'b1;
        drain(20);
        check("t3_idle", out_valid, 0);
        check("t3_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // 4: both full, last-word pop on the capture edge
        out_ready = 1'b0;
        push2(8'h11, 8'h12);
        window(8'h11, 8'h12, -1);
        push2(8'h21, 8'h22);
        window(8'h21, 8'h22, -1);
        push2(8'h31, 8'h32);
        window(8'h31, 8'h32, D - 2);
        pe_en_o = 1'b0;
        check("t4_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_bubble", out_valid, 1);
            tick();
        end
        drain(5);
        check("t4_idle", out_valid, 0);

        // 5: random backpressure
        for (int w = 0; w < 4; w++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            push2(r0, r1);
            for (int i = 0; i < D; i++) begin
                pe_en_o   = 1'b1;
                pe_P      = (i == D - 1) ? {r1, r0} : {r0, r1};
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            pe_en_o = 1'b0;
            for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            out_ready = 1'b1;
            drain(10);
        end
        check("t5_ovf", overflow, 0);

        // 6: reset after word 0 accepted
        out_ready = 1'b0;
        exp_q.push_back('{8'h77, 1'b0, 1'b0});
        window(8'h77, 8'h88, -1);
        pe_en_o   = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_data", out_data, 0);
        check("t6_idx", out_idx, 0);
        check("t6_last", out_last, 0);
        check("t6_ovf", overflow, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pe_en_o = 1'b1;
            pe_P    = 16'h4321;
            tick();
        end
        pe_en_o = 1'b0;
        repeat (3) tick();
        check("t6_quiet", out_valid, 0);
        push2(8'h9A, 8'h9B);
        window(8'h9A, 8'h9B, -1);
        pe_en_o = 1'b0;
        drain(10);
        check("t6_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
